// File: rtl/pdp8lpbin.sv
// PDP-8/L pulse bit input.
// ARM software pushes 32-bit words of sample bytes into a word FIFO. A pacer
// plays one byte out every (samprate+1) CSTEP cycles into curbyte, deriving a
// level bit from a threshold compare and flagging ready. The CPU polls these
// through IOTs on device DEVNO: 6xx1 skips on level, 6xx2 reads the byte into
// AC, and 6xx4 skips on ready and then clears it. The bits may be combined.
//
// Handshakes: the arm side has no handshake. armwrite is a single-cycle
// strobe that always completes, and armrdata is a pure combinational decode
// of armraddr. On the IOT side, iopstart and iopstop act only in a cycle with
// CSTEP=1. Results are registered and stay valid from the CSTEP cycle after
// iopstart until a CSTEP&iopstop cycle clears them.
module pdp8lpbin #(
    parameter logic [5:0] DEVNO  = 6'o05,
    parameter int         LOG2WD = 4,
    parameter logic [7:0] THRESH = 8'h80
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        CSTEP,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    input  logic        iopstart,
    input  logic        iopstop,
    input  logic [11:0] ioopcode,
    input  logic [11:0] cputodev,
    output logic [11:0] devtocpu,
    output logic        AC_CLEAR,
    output logic        IO_SKIP
);

    localparam int DEPTH = 1 << LOG2WD;
    localparam logic [15:0] SAMPRATE_RST = 16'd12499;

    // Configuration and status
    logic                enable_q,    enable_d;
    logic [15:0]         samprate_q,  samprate_d;
    logic                overrun_q,   overrun_d;
    logic                underrun_q,  underrun_d;
    logic                ready_q,     ready_d;
    logic [7:0]          curbyte_q,   curbyte_d;
    logic                level_q,     level_d;
    logic [15:0]         sampcount_q, sampcount_d;

    // FIFO bookkeeping. words_q reaches DEPTH exactly, so its top bit means full.
    logic [31:0]         mem_q [DEPTH];
    logic [LOG2WD-1:0]   wptr_q,      wptr_d;
    logic [LOG2WD-1:0]   rptr_q,      rptr_d;
    logic [LOG2WD:0]     words_q,     words_d;
    logic [1:0]          bidx_q,      bidx_d;

    // Registered IOT results
    logic [11:0]         devtocpu_q,  devtocpu_d;
    logic                acclear_q,   acclear_d;
    logic                ioskip_q,    ioskip_d;

    // Per-cycle decode
    logic                wr_cfg;
    logic                wr_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push_go;
    logic                pop_go;
    logic                pop_word;
    logic                iot_hit;
    logic [31:0]         head_word;
    logic [7:0]          head_byte;
    logic [LOG2WD+2:0]   fifocount;
    logic                unused_ok;

    assign unused_ok  = ^cputodev;

    assign wr_cfg     = armwrite && (armwaddr == 2'd1);
    assign wr_push    = armwrite && (armwaddr == 2'd2);
    assign fifo_full  = words_q[LOG2WD];
    assign fifo_empty = (words_q == '0);
    assign push_go    = wr_push && !fifo_full;
    assign head_word  = mem_q[rptr_q];
    assign fifocount  = {words_q, 2'b00} - {{(LOG2WD+1){1'b0}}, bidx_q};
    assign iot_hit    = CSTEP && iopstart && (ioopcode[11:9] == 3'o6)
                        && (ioopcode[8:3] == DEVNO);

    assign devtocpu   = devtocpu_q;
    assign AC_CLEAR   = acclear_q;
    assign IO_SKIP    = ioskip_q;

    // Select the byte at the play position; bytes go out most significant first
    always_comb begin
        head_byte = 8'h00;
        case (bidx_q)
            2'd0:    head_byte = head_word[31:24];
            2'd1:    head_byte = head_word[23:16];
            2'd2:    head_byte = head_word[15:8];
            default: head_byte = head_word[7:0];
        endcase
    end

    // Next-state logic: pacer, FIFO push/pop, IOT decode, then config write on top
    always_comb begin
        enable_d    = enable_q;
        samprate_d  = samprate_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        ready_d     = ready_q;
        curbyte_d   = curbyte_q;
        level_d     = level_q;
        sampcount_d = sampcount_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        words_d     = words_q;
        bidx_d      = bidx_q;
        devtocpu_d  = devtocpu_q;
        acclear_d   = acclear_q;
        ioskip_d    = ioskip_q;
        pop_go      = 1'b0;
        pop_word    = 1'b0;

        // Pacer: a config write in the same cycle suppresses it
        if (CSTEP && enable_q && !wr_cfg) begin
            if (sampcount_q == samprate_q) begin
                sampcount_d = 16'd0;
                if (fifo_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    pop_go    = 1'b1;
                    curbyte_d = head_byte;
                    level_d   = (head_byte >= THRESH);
                    ready_d   = 1'b1;
                    if (bidx_q == 2'd3) begin
                        bidx_d   = 2'd0;
                        rptr_d   = rptr_q + 1'b1;
                        pop_word = 1'b1;
                    end else begin
                        bidx_d = bidx_q + 2'd1;
                    end
                end
            end else begin
                sampcount_d = sampcount_q + 16'd1;
            end
        end

        // Push side: a word arriving while full is lost and flagged
        if (wr_push && fifo_full) begin
            overrun_d = 1'b1;
        end
        if (push_go) begin
            wptr_d = wptr_q + 1'b1;
        end

        case ({push_go, pop_word})
            2'b10:   words_d = words_q + 1'b1;
            2'b01:   words_d = words_q - 1'b1;
            default: words_d = words_q;
        endcase

        // IOT outputs: the end of the pulse clears, and a new start overrides
        if (CSTEP && iopstop) begin
            devtocpu_d = 12'd0;
            acclear_d  = 1'b0;
            ioskip_d   = 1'b0;
        end
        if (iot_hit) begin
            ioskip_d   = (ioopcode[0] && level_q) || (ioopcode[2] && ready_q);
            acclear_d  = ioopcode[1];
            devtocpu_d = ioopcode[1] ? {4'b0000, curbyte_q} : 12'd0;
            // A byte landing in the same cycle keeps ready raised
            if (ioopcode[2] && !pop_go) begin
                ready_d = 1'b0;
            end
        end

        // Config write restarts playback from an empty FIFO
        if (wr_cfg) begin
            enable_d    = armwdata[31];
            samprate_d  = armwdata[15:0];
            overrun_d   = 1'b0;
            underrun_d  = 1'b0;
            ready_d     = 1'b0;
            curbyte_d   = 8'h00;
            level_d     = 1'b0;
            sampcount_d = 16'd0;
            wptr_d      = '0;
            rptr_d      = '0;
            words_d     = '0;
            bidx_d      = 2'd0;
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            enable_q    <= 1'b0;
            samprate_q  <= SAMPRATE_RST;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            ready_q     <= 1'b0;
            curbyte_q   <= 8'h00;
            level_q     <= 1'b0;
            sampcount_q <= 16'd0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            words_q     <= '0;
            bidx_q      <= 2'd0;
            devtocpu_q  <= 12'd0;
            acclear_q   <= 1'b0;
            ioskip_q    <= 1'b0;
        end else begin
            enable_q    <= enable_d;
            samprate_q  <= samprate_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            ready_q     <= ready_d;
            curbyte_q   <= curbyte_d;
            level_q     <= level_d;
            sampcount_q <= sampcount_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            words_q     <= words_d;
            bidx_q      <= bidx_d;
            devtocpu_q  <= devtocpu_d;
            acclear_q   <= acclear_d;
            ioskip_q    <= ioskip_d;
        end
    end

    // FIFO storage; contents only matter where the pointers say they are valid
    always_ff @(posedge CLOCK) begin
        if (push_go) begin
            mem_q[wptr_q] <= armwdata;
        end
    end

    // Arm register read decode
    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            2'd0:    armrdata = 32'h50491004;
            2'd1:    armrdata = {enable_q, overrun_q, underrun_q, 5'b00000,
                                 level_q, 7'(fifocount), samprate_q};
            2'd2:    armrdata = {24'd0, curbyte_q};
            default: armrdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_pdp8lpbin.sv
// Bench for pdp8lpbin: directed scenarios plus randomized traffic, all
// compared every cycle against a byte-queue reference model.
module tb_pdp8lpbin;

  localparam int FIFO_BYTES = 64;

  logic        CLOCK;
  logic        RESET;
  logic        CSTEP;
  logic        armwrite;
  logic [1:0]  armraddr;
  logic [1:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        iopstart;
  logic        iopstop;
  logic [11:0] ioopcode;
  logic [11:0] cputodev;
  logic [11:0] devtocpu;
  logic        AC_CLEAR;
  logic        IO_SKIP;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic        m_en;
  logic [15:0] m_rate;
  logic        m_ovr;
  logic        m_und;
  logic        m_rdy;
  logic [7:0]  m_cur;
  logic        m_lvl;
  int          m_cnt;
  logic [7:0]  bq[$];
  logic [11:0] m_dev;
  logic        m_clr;
  logic        m_skip;

  pdp8lpbin dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .CSTEP    (CSTEP),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .iopstart (iopstart),
    .iopstop  (iopstop),
    .ioopcode (ioopcode),
    .cputodev (cputodev),
    .devtocpu (devtocpu),
    .AC_CLEAR (AC_CLEAR),
    .IO_SKIP  (IO_SKIP)
  );

  // Clock and reset
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_rate = 16'd12499; m_ovr = 1'b0; m_und = 1'b0;
    m_rdy = 1'b0; m_cur = 8'h00; m_lvl = 1'b0; m_cnt = 0;
    bq.delete();
    m_dev = 12'd0; m_clr = 1'b0; m_skip = 1'b0;
  endtask

  function automatic logic [31:0] exp_reg1();
    return {m_en, m_ovr, m_und, 5'b00000, m_lvl, 7'(bq.size()), m_rate};
  endfunction

  // Advance the model by one clock using the inputs currently driven
  task automatic model_step();
    bit wr1, wr2, full_b, popped;
    logic old_lvl, old_rdy;
    logic [7:0] old_cur, b;
    wr1 = armwrite && (armwaddr == 2'd1);
    wr2 = armwrite && (armwaddr == 2'd2);
    // a partly played word still occupies a whole slot
    full_b  = ((bq.size() + 3) / 4) >= (FIFO_BYTES / 4);
    old_lvl = m_lvl; old_rdy = m_rdy; old_cur = m_cur;
    popped  = 1'b0;
    if (CSTEP && m_en && !wr1) begin
      if (m_cnt == int'(m_rate)) begin
        m_cnt = 0;
        if (bq.size() > 0) begin
          b = bq.pop_front();
          m_cur = b; m_lvl = (b >= 8'h80); m_rdy = 1'b1; popped = 1'b1;
        end else begin
          m_und = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
    if (wr2) begin
      if (full_b) m_ovr = 1'b1;
      else begin
        bq.push_back(armwdata[31:24]); bq.push_back(armwdata[23:16]);
        bq.push_back(armwdata[15:8]);  bq.push_back(armwdata[7:0]);
      end
    end
    if (CSTEP && iopstop) begin
      m_dev = 12'd0; m_clr = 1'b0; m_skip = 1'b0;
    end
    if (CSTEP && iopstart && ioopcode[11:9] == 3'o6 && ioopcode[8:3] == 6'o05) begin
      m_skip = (ioopcode[0] & old_lvl) | (ioopcode[2] & old_rdy);
      m_clr  = ioopcode[1];
      m_dev  = ioopcode[1] ? {4'b0000, old_cur} : 12'd0;
      if (ioopcode[2] && !popped) m_rdy = 1'b0;
    end
    if (wr1) begin
      m_en = armwdata[31]; m_rate = armwdata[15:0];
      bq.delete();
      m_ovr = 1'b0; m_und = 1'b0; m_rdy = 1'b0; m_cur = 8'h00; m_lvl = 1'b0; m_cnt = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ".devtocpu"}, {20'd0, devtocpu}, {20'd0, m_dev});
    check({where, ".AC_CLEAR"}, {31'd0, AC_CLEAR}, {31'd0, m_clr});
    check({where, ".IO_SKIP"},  {31'd0, IO_SKIP},  {31'd0, m_skip});
  endtask

  // One clock: model, edge, then compare outputs and status registers
  task automatic cycle();
    model_step();
    @(posedge CLOCK);
    #1;
    armwrite = 1'b0; iopstart = 1'b0; iopstop = 1'b0;
    check_outputs("cyc");
    armraddr = 2'd1; #1;
    check("reg1", armrdata, exp_reg1());
    armraddr = 2'd2; #1;
    check("reg2", armrdata, {24'd0, m_cur});
  endtask

  // Driver tasks
  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    CSTEP = 1'b0; armwrite = 1'b1; armwaddr = a; armwdata = d;
    cycle();
  endtask

  task automatic run(input int n);
    CSTEP = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic iot(input logic [11:0] op);
    CSTEP = 1'b1; ioopcode = op; iopstart = 1'b1;
    cycle();
    iopstop = 1'b1;
    cycle();
  endtask

  initial begin
    RESET = 1'b1; CSTEP = 1'b0; armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0;
    armwdata = 32'd0; iopstart = 1'b0; iopstop = 1'b0; ioopcode = 12'd0; cputodev = 12'd0;
    model_reset();
    repeat (2) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    #1;
    // Reset state
    armraddr = 2'd0; #1;
    check("id_reg0", armrdata, 32'h50491004);
    armraddr = 2'd1; #1;
    check("reset_reg1", armrdata, 32'h000030D3);
    armraddr = 2'd3; #1;
    check("reg3", armrdata, 32'd0);
    check_outputs("reset");

    // Four-byte playback at 4-cycle spacing, then underrun
    arm_wr(2'd1, 32'h80000003);
    arm_wr(2'd2, 32'h00FF407F);
    run(20);
    arm_wr(2'd3, 32'hFFFFFFFF);

    // Byte read with skip on level/ready, then ready found cleared
    arm_wr(2'd1, 32'h80000003);
    arm_wr(2'd2, 32'hFF000000);
    run(4);
    iot(12'o6057);
    iot(12'o6054);

    // Pop coincides with 6054: ready survives
    arm_wr(2'd1, 32'h80000003);
    arm_wr(2'd2, 32'h11223344);
    run(3);
    iot(12'o6054);
    iot(12'o6054);

    // Wrong device and single-function IOTs
    iot(12'o6061);
    iot(12'o6052);
    iot(12'o6051);

    // Overflow with playback disabled
    arm_wr(2'd1, 32'h00000000);
    for (int i = 0; i < 17; i++) arm_wr(2'd2, $urandom);
    arm_wr(2'd1, 32'h00000000);

    // Asynchronous reset in the middle of an IOT
    arm_wr(2'd1, 32'h80000000);
    arm_wr(2'd2, 32'h90000000);
    run(1);
    CSTEP = 1'b1; ioopcode = 12'o6055; iopstart = 1'b1;
    cycle();
    #2;
    RESET = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    armraddr = 2'd1; #1;
    check("async_rst.reg1", armrdata, 32'h000030D3);
    #1;
    RESET = 1'b0;
    @(posedge CLOCK);
    #1;

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      armwrite = ($urandom_range(0, 7) == 0);
      armwaddr = 2'($urandom_range(0, 3));
      armwdata = $urandom;
      if (armwaddr == 2'd1)
        armwdata = {($urandom_range(0, 3) != 0), 15'($urandom), 16'($urandom_range(0, 5))};
      CSTEP    = ($urandom_range(0, 3) != 0);
      iopstart = ($urandom_range(0, 5) == 0);
      iopstop  = !iopstart && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 7) ioopcode = {3'o6, 6'o05, 3'($urandom_range(0, 7))};
      else ioopcode = 12'($urandom);
      cputodev = 12'($urandom);
      cycle();
    end

    // Report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
